// File: rtl/abus_master_pkg.sv
// Shared definitions for the A-bus initiator: FSM state codes, chip-select codes
// and the fixed data words returned on reserved-CS reads and watchdog timeouts.
package abus_master_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_TURN   = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_RECOV  = 3'd5;
  localparam logic [2:0] ST_RSVD   = 3'd6;

  typedef enum logic [1:0] {
    CS_SEL_0    = 2'b00,
    CS_SEL_1    = 2'b01,
    CS_SEL_2    = 2'b10,
    CS_SEL_RSVD = 2'b11
  } cs_sel_e;

  localparam logic [15:0] READ_TIMEOUT_DATA = 16'hDEAD;
  localparam logic [15:0] RSVD_READ_DATA    = 16'hFFFF;

  localparam int TIMER_W = 8;

  // Active-low one-hot chip-select pattern for a select code.
  function automatic logic [2:0] cs_decode(input logic [1:0] sel);
    case (sel)
      CS_SEL_0: return 3'b110;
      CS_SEL_1: return 3'b101;
      CS_SEL_2: return 3'b011;
      default:  return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/abus_phase_timer.sv
// Loadable down-counter timing each A-bus phase; o_done is high while the count is zero.
module abus_phase_timer #(
  parameter int W = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/abus_master_driver.sv
// A-bus initiator: turns Avalon-MM commands into multiplexed address/data A-bus cycles.
// Define ABUS_MASTER_TIMEOUT_EN to add a STROBE watchdog (forces HOLD, returns 0xDEAD, sets error).
module abus_master_driver
  import abus_master_pkg::*;
#(
  parameter int T_ADDR   = 2,
  parameter int T_TURN   = 1,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 1,
  parameter int T_RECOV  = 2
`ifdef ABUS_MASTER_TIMEOUT_EN
  ,
  parameter int TO_MAX   = 1023
`endif
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [23:0] i_avs_address,
  input  logic        i_avs_read,
  input  logic        i_avs_write,
  input  logic [15:0] i_avs_writedata,
  input  logic [1:0]  i_avs_byteenable,
  output logic [15:0] o_avs_readdata,
  output logic        o_avs_readdatavalid,
  output logic        o_avs_waitrequest,
  output logic [9:0]  o_abus_address,
  output logic [15:0] o_abus_ad_out,
  output logic        o_abus_ad_oe,
  input  logic [15:0] i_abus_ad_in,
  output logic [2:0]  o_abus_chipselect_n,
  output logic        o_abus_read_n,
  output logic [1:0]  o_abus_wbe_n,
  input  logic        i_abus_waitrequest,
  output logic        o_error
);

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic               r_waitrequest;
  logic               r_is_read;
  logic [1:0]         r_cs_sel;
  logic [9:0]         r_abus_addr;
  logic [11:0]        r_addr_lo;
  logic [15:0]        r_wdata;
  logic [1:0]         r_be;
  logic [15:0]        r_readdata;
  logic               r_readdatavalid;
  logic               r_error;
  logic               r_wait_meta;
  logic               r_wait_sync;
  logic               w_accept;
  logic               w_rsvd;
  logic               w_timeout;
  logic               w_strobe_end;
  logic               w_timer_done;
  logic               w_timer_load;
  logic [TIMER_W-1:0] w_timer_val;

  assign w_accept = (i_avs_read | i_avs_write) & ~r_waitrequest & (r_state == ST_IDLE);
  assign w_rsvd   = (i_avs_address[23:22] == CS_SEL_RSVD);

  // Wait is only honoured once the minimum strobe width has elapsed.
  assign w_strobe_end = (r_state == ST_STROBE) && ((w_timer_done && !r_wait_sync) || w_timeout);

`ifdef ABUS_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_MAX + 1);
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_STROBE) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_timeout = (r_state == ST_STROBE) && (r_to_cnt == TO_W'(TO_MAX - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_next = w_rsvd ? ST_RSVD : ST_ADDR;
      ST_ADDR:   if (w_timer_done) w_state_next = r_is_read ? ST_TURN : ST_STROBE;
      ST_TURN:   if (w_timer_done) w_state_next = ST_STROBE;
      ST_STROBE: if (w_strobe_end) w_state_next = ST_HOLD;
      ST_HOLD:   if (w_timer_done) w_state_next = ST_RECOV;
      ST_RECOV:  if (w_timer_done) w_state_next = ST_IDLE;
      ST_RSVD:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Timer is reloaded with (phase length - 1) on every state entry.
  assign w_timer_load = (w_state_next != r_state);

  always_comb begin
    case (w_state_next)
      ST_ADDR:   w_timer_val = TIMER_W'(T_ADDR - 1);
      ST_TURN:   w_timer_val = TIMER_W'(T_TURN - 1);
      ST_STROBE: w_timer_val = TIMER_W'(T_STROBE - 1);
      ST_HOLD:   w_timer_val = TIMER_W'(T_HOLD - 1);
      ST_RECOV:  w_timer_val = TIMER_W'(T_RECOV - 1);
      default:   w_timer_val = '0;
    endcase
  end

  abus_phase_timer #(
    .W (TIMER_W)
  ) u_phase_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .o_done     (w_timer_done)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_waitrequest <= 1'b1;
      r_wait_meta   <= 1'b0;
      r_wait_sync   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_waitrequest <= (w_state_next != ST_IDLE);
      r_wait_meta   <= i_abus_waitrequest;
      r_wait_sync   <= r_wait_meta;
    end
  end

  // Command latch; a simultaneous read and write is treated as a read.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_is_read   <= 1'b0;
      r_cs_sel    <= CS_SEL_0;
      r_abus_addr <= '0;
      r_addr_lo   <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
    end else if (w_accept) begin
      r_is_read   <= i_avs_read;
      r_cs_sel    <= i_avs_address[23:22];
      r_abus_addr <= i_avs_address[21:12];
      r_addr_lo   <= i_avs_address[11:0];
      r_wdata     <= i_avs_writedata;
      r_be        <= i_avs_byteenable;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_readdatavalid <= 1'b0;
      if (w_accept && w_rsvd) begin
        r_error <= 1'b1;
        if (i_avs_read) begin
          r_readdata      <= RSVD_READ_DATA;
          r_readdatavalid <= 1'b1;
        end
      end
      if (w_strobe_end && r_is_read) begin
        r_readdata <= w_timeout ? READ_TIMEOUT_DATA : i_abus_ad_in;
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
      if (r_state == ST_HOLD && w_state_next == ST_RECOV && r_is_read) begin
        r_readdatavalid <= 1'b1;
      end
    end
  end

  always_comb begin
    o_abus_chipselect_n = 3'b111;
    o_abus_read_n       = 1'b1;
    o_abus_wbe_n        = 2'b11;
    o_abus_ad_oe        = 1'b0;
    o_abus_ad_out       = '0;
    case (r_state)
      ST_ADDR: begin
        o_abus_chipselect_n = cs_decode(r_cs_sel);
        o_abus_ad_oe        = 1'b1;
        o_abus_ad_out       = {r_addr_lo, 4'b0000};
      end
      ST_TURN: begin
        o_abus_chipselect_n = cs_decode(r_cs_sel);
      end
      ST_STROBE: begin
        o_abus_chipselect_n = cs_decode(r_cs_sel);
        if (r_is_read) begin
          o_abus_read_n = 1'b0;
        end else begin
          o_abus_wbe_n  = ~r_be;
          o_abus_ad_oe  = 1'b1;
          o_abus_ad_out = r_wdata;
        end
      end
      ST_HOLD: begin
        o_abus_chipselect_n = cs_decode(r_cs_sel);
        if (!r_is_read) begin
          o_abus_ad_oe  = 1'b1;
          o_abus_ad_out = r_wdata;
        end
      end
      default: ;
    endcase
  end

  assign o_abus_address      = r_abus_addr;
  assign o_avs_readdata      = r_readdata;
  assign o_avs_readdatavalid = r_readdatavalid;
  assign o_avs_waitrequest   = r_waitrequest;
  assign o_error             = r_error;

endmodule

// File: tb/tb_abus_master_driver.sv
// Directed bench for abus_master_driver; the watchdog case runs only with ABUS_MASTER_TIMEOUT_EN.
module tb_abus_master_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [15:0] avs_writedata = '0;
  logic [1:0]  avs_byteenable = '0;
  logic [15:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic [9:0]  abus_address;
  logic [15:0] abus_ad_out;
  logic        abus_ad_oe;
  logic [15:0] abus_ad_in = '0;
  logic [2:0]  abus_cs_n;
  logic        abus_read_n;
  logic [1:0]  abus_wbe_n;
  logic        abus_wait = 1'b0;
  logic        error;

  abus_master_driver dut (
    .i_clock             (clk),
    .i_reset             (rst),
    .i_avs_address       (avs_address),
    .i_avs_read          (avs_read),
    .i_avs_write         (avs_write),
    .i_avs_writedata     (avs_writedata),
    .i_avs_byteenable    (avs_byteenable),
    .o_avs_readdata      (avs_readdata),
    .o_avs_readdatavalid (avs_readdatavalid),
    .o_avs_waitrequest   (avs_waitrequest),
    .o_abus_address      (abus_address),
    .o_abus_ad_out       (abus_ad_out),
    .o_abus_ad_oe        (abus_ad_oe),
    .i_abus_ad_in        (abus_ad_in),
    .o_abus_chipselect_n (abus_cs_n),
    .o_abus_read_n       (abus_read_n),
    .o_abus_wbe_n        (abus_wbe_n),
    .i_abus_waitrequest  (abus_wait),
    .o_error             (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: cumulative counters sampled on the falling edge.
  logic [15:0] exp_wdata = '0;
  int          cs_low_cnt = 0, wbe_low_cnt = 0, rdn_low_cnt = 0, rdv_cnt = 0, wreq_cnt = 0;
  int          strobe_bad = 0, gap_run = 0, last_gap = 0;
  logic        prev_cs_low = 1'b0;
  logic        last_addr_oe = 1'b0;
  logic [15:0] last_addr_ad = '0, last_rdata = '0;
  logic [2:0]  last_cs = 3'b111;

  always @(negedge clk) begin
    if (!rst) begin
      if (abus_cs_n != 3'b111) begin
        cs_low_cnt <= cs_low_cnt + 1;
        if (!prev_cs_low) begin
          last_gap     <= gap_run;
          last_addr_ad <= abus_ad_out;
          last_addr_oe <= abus_ad_oe;
          last_cs      <= abus_cs_n;
        end
        gap_run     <= 0;
        prev_cs_low <= 1'b1;
      end else begin
        gap_run     <= gap_run + 1;
        prev_cs_low <= 1'b0;
      end
      if (abus_wbe_n != 2'b11) begin
        wbe_low_cnt <= wbe_low_cnt + 1;
        if (abus_ad_out !== exp_wdata || !abus_ad_oe) strobe_bad <= strobe_bad + 1;
      end
      if (!abus_read_n) begin
        rdn_low_cnt <= rdn_low_cnt + 1;
        if (abus_ad_oe) strobe_bad <= strobe_bad + 1;
      end
      if (avs_readdatavalid) begin
        rdv_cnt    <= rdv_cnt + 1;
        last_rdata <= avs_readdata;
      end
      if (avs_waitrequest) wreq_cnt <= wreq_cnt + 1;
    end
  end

  int s_cs, s_wbe, s_rdn, s_rdv, s_wreq, s_bad;

  task automatic snap();
    @(negedge clk);
    s_cs = cs_low_cnt; s_wbe = wbe_low_cnt; s_rdn = rdn_low_cnt;
    s_rdv = rdv_cnt; s_wreq = wreq_cnt; s_bad = strobe_bad;
  endtask

  task automatic do_cmd(input logic rd, input logic wr, input logic [23:0] addr,
                        input logic [15:0] wd, input logic [1:0] be);
    int n = 0;
    @(negedge clk);
    while (avs_waitrequest && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_bound", 32'(n < 100), 32'd1);
    avs_address = addr; avs_read = rd; avs_write = wr;
    avs_writedata = wd; avs_byteenable = be;
    @(posedge clk);
    #1;
    avs_read = 1'b0; avs_write = 1'b0;
    $display("txn rd=%0b wr=%0b addr=0x%06h wdata=0x%04h be=%02b", rd, wr, addr, wd, be);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (avs_waitrequest && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_bound", 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int lows;
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs_n",  32'(abus_cs_n), 32'h7);
    check("rst_read_n", 32'(abus_read_n), 32'h1);
    check("rst_wbe_n", 32'(abus_wbe_n), 32'h3);
    check("rst_ad_oe", 32'(abus_ad_oe), 32'h0);
    check("rst_ad_out", 32'(abus_ad_out), 32'h0);
    check("rst_rdata", 32'(avs_readdata), 32'h0);
    check("rst_rdv", 32'(avs_readdatavalid), 32'h0);
    check("rst_wreq", 32'(avs_waitrequest), 32'h1);
    check("rst_error", 32'(error), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: write CS0, no wait
    exp_wdata = 16'hA55A;
    snap();
    do_cmd(1'b0, 1'b1, 24'h010100, 16'hA55A, 2'b11);
    wait_done(100);
    check("w1_cs_low", 32'(cs_low_cnt - s_cs), 32'd7);
    check("w1_wreq_high", 32'(wreq_cnt - s_wreq), 32'd9);
    check("w1_wbe_low", 32'(wbe_low_cnt - s_wbe), 32'd4);
    check("w1_strobe_data", 32'(strobe_bad - s_bad), 32'd0);
    check("w1_addr_ad", 32'(last_addr_ad), 32'h1000);
    check("w1_addr_oe", 32'(last_addr_oe), 32'h1);
    check("w1_cs", 32'(last_cs), 32'h6);
    check("w1_upper_addr", 32'(abus_address), 32'h010);
    check("w1_no_read", 32'(rdn_low_cnt - s_rdn), 32'd0);

    // 2: read CS1, wait stretched: released after 10 low samples -> 2-FF sync -> 12 clocks low
    abus_ad_in = 16'h1234;
    abus_wait  = 1'b1;
    snap();
    do_cmd(1'b1, 1'b0, 24'h400002, 16'h0000, 2'b11);
    lows = 0;
    n    = 0;
    while (lows < 10 && n < 200) begin
      @(negedge clk);
      if (!abus_read_n) lows++;
      n++;
    end
    abus_wait = 1'b0;
    wait_done(100);
    check("r2_read_n_low", 32'(rdn_low_cnt - s_rdn), 32'd12);
    check("r2_cs_low", 32'(cs_low_cnt - s_cs), 32'd16);
    check("r2_rdv_once", 32'(rdv_cnt - s_rdv), 32'd1);
    check("r2_rdata", 32'(last_rdata), 32'h1234);
    check("r2_rdata_held", 32'(avs_readdata), 32'h1234);
    check("r2_addr_ad", 32'(last_addr_ad), 32'h0020);
    check("r2_cs", 32'(last_cs), 32'h5);
    check("r2_no_wbe", 32'(wbe_low_cnt - s_wbe), 32'd0);
    check("r2_oe_off", 32'(strobe_bad - s_bad), 32'd0);

    // 3: read+write together (read wins), then back-to-back write with be=01 on CS2
    abus_ad_in = 16'h5A5A;
    exp_wdata  = 16'h0F0F;
    snap();
    do_cmd(1'b1, 1'b1, 24'h800ABC, 16'hFFFF, 2'b11);
    do_cmd(1'b0, 1'b1, 24'h800ABD, 16'h0F0F, 2'b01);
    wait_done(100);
    check("b3_rdv_once", 32'(rdv_cnt - s_rdv), 32'd1);
    check("b3_rdata", 32'(last_rdata), 32'h5A5A);
    check("b3_wbe_only_write", 32'(wbe_low_cnt - s_wbe), 32'd4);
    check("b3_read_n_low", 32'(rdn_low_cnt - s_rdn), 32'd4);
    check("b3_strobe_data", 32'(strobe_bad - s_bad), 32'd0);
    // 2 RECOV clocks plus the IDLE clock on which the held command is accepted
    check("b3_gap", 32'(last_gap), 32'd3);
    check("b3_addr_ad", 32'(last_addr_ad), 32'hABD0);
    check("b3_cs", 32'(last_cs), 32'h3);

    // byteenable=00: full-timing cycle, strobes stay high
    snap();
    do_cmd(1'b0, 1'b1, 24'h000001, 16'h2222, 2'b00);
    wait_done(100);
    check("be0_cs_low", 32'(cs_low_cnt - s_cs), 32'd7);
    check("be0_wreq_high", 32'(wreq_cnt - s_wreq), 32'd9);
    check("be0_wbe_low", 32'(wbe_low_cnt - s_wbe), 32'd0);
    check("pre_rsvd_error", 32'(error), 32'h0);

    // 4: reserved CS
    snap();
    do_cmd(1'b0, 1'b1, 24'hC00123, 16'h1111, 2'b11);
    wait_done(100);
    check("rsvd_w_cs", 32'(cs_low_cnt - s_cs), 32'd0);
    check("rsvd_w_wbe", 32'(wbe_low_cnt - s_wbe), 32'd0);
    check("rsvd_w_error", 32'(error), 32'h1);
    snap();
    do_cmd(1'b1, 1'b0, 24'hC00456, 16'h0000, 2'b11);
    wait_done(100);
    check("rsvd_r_cs", 32'(cs_low_cnt - s_cs), 32'd0);
    check("rsvd_r_read_n", 32'(rdn_low_cnt - s_rdn), 32'd0);
    check("rsvd_r_rdv", 32'(rdv_cnt - s_rdv), 32'd1);
    check("rsvd_r_rdata", 32'(last_rdata), 32'hFFFF);

    // 5: asynchronous reset in the middle of a read strobe
    abus_wait = 1'b1;
    do_cmd(1'b1, 1'b0, 24'h000010, 16'h0000, 2'b11);
    n = 0;
    while (abus_read_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_strobe_reached", 32'(abus_read_n), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cs_n", 32'(abus_cs_n), 32'h7);
    check("arst_read_n", 32'(abus_read_n), 32'h1);
    check("arst_ad_oe", 32'(abus_ad_oe), 32'h0);
    check("arst_wreq", 32'(avs_waitrequest), 32'h1);
    check("arst_error", 32'(error), 32'h0);
    abus_wait = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_wdata = 16'h3C3C;
    snap();
    do_cmd(1'b0, 1'b1, 24'h000020, 16'h3C3C, 2'b10);
    wait_done(100);
    check("post_rst_cs_low", 32'(cs_low_cnt - s_cs), 32'd7);
    check("post_rst_wbe_low", 32'(wbe_low_cnt - s_wbe), 32'd4);
    check("post_rst_cs", 32'(last_cs), 32'h6);

`ifdef ABUS_MASTER_TIMEOUT_EN
    // 6: responder never releases wait
    abus_wait = 1'b1;
    snap();
    do_cmd(1'b1, 1'b0, 24'h000030, 16'h0000, 2'b11);
    wait_done(2000);
    check("to_read_n_low", 32'(rdn_low_cnt - s_rdn), 32'd1023);
    check("to_rdata", 32'(last_rdata), 32'hDEAD);
    check("to_error", 32'(error), 32'h1);
    abus_wait = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
